// File: rtl/csi2_packet_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : csi2_packet_tx_if
// Description : Packet request, payload and two-lane HS byte bundle for the
//               CSI-2 packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface csi2_packet_tx_if;
    logic        pkt_start;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic [15:0] pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  lane0_byte;
    logic [7:0]  lane1_byte;
    logic        byte_valid;
    logic        hs_req;
    logic        busy;
    logic        pkt_err;
    logic        underrun;

    modport master (
        output pkt_start, pkt_vc, pkt_dt, pkt_wc, pay_data, pay_valid,
        input  pay_ready, lane0_byte, lane1_byte, byte_valid, hs_req, busy,
               pkt_err, underrun
    );

    modport slave (
        input  pkt_start, pkt_vc, pkt_dt, pkt_wc, pay_data, pay_valid,
        output pay_ready, lane0_byte, lane1_byte, byte_valid, hs_req, busy,
               pkt_err, underrun
    );
endinterface
`default_nettype wire

// File: rtl/csi2_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : csi2_packet_tx
// Description : Two-lane MIPI CSI-2 packet sequencer: HS-prepare, SoT sync,
//               ECC-protected header, payload, CRC-16 and HS trail.
// Revision    : 1.0 - initial release
// ============================================================================
module csi2_packet_tx #(
    parameter int PREP_CYCLES = 4,
    parameter int TRAIL_BYTES = 2
) (
    input  logic            sys_clk,
    input  logic            reset,
    csi2_packet_tx_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_HDR0  = 3'd3,
        ST_HDR1  = 3'd4,
        ST_PAY   = 3'd5,
        ST_CRC   = 3'd6,
        ST_TRAIL = 3'd7
    } state_t;

    localparam logic [14:0] c_prep_load  = 15'(PREP_CYCLES - 1);
    localparam logic [14:0] c_trail_load = 15'(TRAIL_BYTES - 1);
    localparam logic [7:0]  c_sync_byte  = 8'hB8;
    localparam logic [15:0] c_crc_init   = 16'hFFFF;

    // Header bits covered by each ECC parity bit, P5 down to P0
    localparam logic [5:0][23:0] c_ecc_mask = {
        24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
        24'h749A6D, 24'hF2555B, 24'hF12CB7
    };

    function automatic logic [7:0] ecc_calc(input logic [23:0] hdr);
        logic [7:0] ecc;
        ecc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            ecc[i] = ^(hdr & c_ecc_mask[i]);
        end
        return ecc;
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc[0] ^ data[i]) begin
                crc = (crc >> 1) ^ 16'h8408;
            end else begin
                crc = crc >> 1;
            end
        end
        return crc;
    endfunction

    state_t      r_state;
    logic [14:0] r_cnt;
    logic [7:0]  r_di;
    logic [15:0] r_wc;
    logic [15:0] r_crc;
    logic [7:0]  r_lane0;
    logic [7:0]  r_lane1;
    logic        r_hs_req;
    logic        r_byte_valid;
    logic        r_busy;
    logic        r_pay_ready;
    logic        r_pkt_err;
    logic        r_underrun;

    logic        w_req_long;
    logic        w_hdr_long;
    logic [15:0] w_pay_word;
    logic [15:0] w_crc_pay;
    logic [7:0]  w_ecc;
    logic [7:0]  w_trail0;
    logic [7:0]  w_trail1;

    assign w_req_long = (bus.pkt_dt[5:4] != 2'b00);
    assign w_hdr_long = (r_di[5:4] != 2'b00);
    // A starved payload slot still goes out, as zeros, so the HS burst never stalls
    assign w_pay_word = bus.pay_valid ? bus.pay_data : 16'h0000;
    assign w_crc_pay  = crc_byte(crc_byte(r_crc, w_pay_word[7:0]), w_pay_word[15:8]);
    assign w_ecc      = ecc_calc({r_wc, r_di});
    assign w_trail0   = r_lane0[7] ? 8'h00 : 8'hFF;
    assign w_trail1   = r_lane1[7] ? 8'h00 : 8'hFF;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 15'd0;
            r_di         <= 8'h00;
            r_wc         <= 16'h0000;
            r_crc        <= c_crc_init;
            r_lane0      <= 8'h00;
            r_lane1      <= 8'h00;
            r_hs_req     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_pay_ready  <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pkt_start) begin
                        if (w_req_long && bus.pkt_wc[0]) begin
                            r_pkt_err <= 1'b1;
                        end else begin
                            r_state    <= ST_PREP;
                            r_di       <= {bus.pkt_vc, bus.pkt_dt};
                            r_wc       <= bus.pkt_wc;
                            r_cnt      <= c_prep_load;
                            r_hs_req   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_pkt_err  <= 1'b0;
                            r_underrun <= 1'b0;
                        end
                    end
                end
                ST_PREP: begin
                    if (r_cnt == 15'd0) begin
                        r_state      <= ST_SYNC;
                        r_byte_valid <= 1'b1;
                        r_lane0      <= c_sync_byte;
                        r_lane1      <= c_sync_byte;
                    end else begin
                        r_cnt <= r_cnt - 15'd1;
                    end
                end
                ST_SYNC: begin
                    r_state <= ST_HDR0;
                    r_lane0 <= r_di;
                    r_lane1 <= r_wc[7:0];
                end
                ST_HDR0: begin
                    r_state <= ST_HDR1;
                    r_lane0 <= r_wc[15:8];
                    r_lane1 <= w_ecc;
                end
                ST_HDR1: begin
                    r_crc <= c_crc_init;
                    if (!w_hdr_long) begin
                        r_state <= ST_TRAIL;
                        r_cnt   <= c_trail_load;
                        r_lane0 <= w_trail0;
                        r_lane1 <= w_trail1;
                    end else if (r_wc[15:1] == 15'd0) begin
                        r_state <= ST_CRC;
                        r_lane0 <= c_crc_init[7:0];
                        r_lane1 <= c_crc_init[15:8];
                    end else begin
                        r_state     <= ST_PAY;
                        r_cnt       <= r_wc[15:1] - 15'd1;
                        r_pay_ready <= 1'b1;
                    end
                end
                ST_PAY: begin
                    r_crc <= w_crc_pay;
                    if (!bus.pay_valid) begin
                        r_underrun <= 1'b1;
                    end
                    if (r_cnt == 15'd0) begin
                        r_state     <= ST_CRC;
                        r_pay_ready <= 1'b0;
                        r_lane0     <= w_crc_pay[7:0];
                        r_lane1     <= w_crc_pay[15:8];
                    end else begin
                        r_cnt <= r_cnt - 15'd1;
                    end
                end
                ST_CRC: begin
                    r_state <= ST_TRAIL;
                    r_cnt   <= c_trail_load;
                    r_lane0 <= w_trail0;
                    r_lane1 <= w_trail1;
                end
                ST_TRAIL: begin
                    if (r_cnt == 15'd0) begin
                        r_state      <= ST_IDLE;
                        r_hs_req     <= 1'b0;
                        r_byte_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_lane0      <= 8'h00;
                        r_lane1      <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt - 15'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload bytes pass straight through so the word accepted this cycle is the word sent
    assign bus.lane0_byte = (r_state == ST_PAY) ? w_pay_word[7:0]  : r_lane0;
    assign bus.lane1_byte = (r_state == ST_PAY) ? w_pay_word[15:8] : r_lane1;
    assign bus.byte_valid = r_byte_valid;
    assign bus.hs_req     = r_hs_req;
    assign bus.busy       = r_busy;
    assign bus.pay_ready  = r_pay_ready;
    assign bus.pkt_err    = r_pkt_err;
    assign bus.underrun   = r_underrun;

endmodule
`default_nettype wire

// File: doc/csi2_packet_tx.md
CSI2_PACKET_TX -- requirements
Module: csi2_packet_tx

Interface
REQ-001 Parameter PREP_CYCLES, default 4, SHALL set the number of HS-prepare cycles: hs_req high, byte_valid low, lanes 0x00.
REQ-002 Parameter TRAIL_BYTES, default 2, SHALL set the number of HS-trail byte cycles per packet.
REQ-003 sys_clk  in  1  single byte clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pkt_start  in  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-006 pkt_vc  in  2  virtual channel, DI[7:6].
REQ-007 pkt_dt  in  6  data type, DI[5:0].
REQ-008 pkt_wc  in  16  word count (long packet) or data field (short packet).
REQ-009 pay_data  in  16  payload; [7:0] goes to lane0, [15:8] to lane1.
REQ-010 pay_valid  in  1  pay_data valid.
REQ-011 pay_ready  out  1  payload word consumed this cycle.
REQ-012 lane0_byte, lane1_byte  out  8 each  HS byte per lane, LSB transmitted first.
REQ-013 byte_valid  out  1  lane bytes are SoT/header/payload/CRC/trail.
REQ-014 hs_req  out  1  HS mode request for the lane PHY and termination.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 pkt_err  out  1  sticky: odd long-packet word count rejected.
REQ-017 underrun  out  1  sticky: payload starvation occurred.

Function
REQ-018 Long packet: pkt_dt >= 0x10. Short packet: pkt_dt <= 0x0F, with no payload and no CRC.
REQ-019 The FSM SHALL have states IDLE, PREP, SYNC, HDR0, HDR1, PAY, CRC, TRAIL.
- IDLE->PREP on pkt_start when the request is valid.
- PREP->SYNC after PREP_CYCLES cycles.
- SYNC->HDR0->HDR1.
- HDR1->PAY for a long packet with WC>0; HDR1->CRC for a long packet with WC=0; HDR1->TRAIL for a short packet.
- PAY->CRC after WC/2 cycles.
- CRC->TRAIL.
- TRAIL->IDLE after TRAIL_BYTES cycles.
REQ-020 On the pkt_start edge, pkt_vc, pkt_dt and pkt_wc SHALL be registered; input changes afterwards have no effect on the packet.
REQ-021 A long packet with pkt_wc[0]=1 SHALL be rejected: the FSM stays in IDLE, pkt_err is set, and no hs_req is raised.
REQ-022 hs_req SHALL rise on the first PREP cycle and fall on the cycle after the last TRAIL cycle.
REQ-023 byte_valid SHALL be high in SYNC, HDR0, HDR1, PAY, CRC and TRAIL, and low otherwise.
REQ-024 SYNC SHALL drive 0xB8 on both lanes.
REQ-025 HDR0 SHALL drive lane0=DI and lane1=WC[7:0]; HDR1 SHALL drive lane0=WC[15:8] and lane1=ECC.
REQ-026 ECC[5:0] SHALL be the CSI-2 Hamming code over the 24 header bits:
- header bit b0..b7 = DI, b8..b15 = WC lo, b16..b23 = WC hi.
- ECC[7:6] = 0.
- Each parity bit is identical to the receiver's check equations, so a packet we send loops back with syndrome 0.
REQ-027 In PAY, pay_ready SHALL be high every cycle. With pay_valid=1, lanes carry pay_data.
REQ-028 In PAY with pay_valid=0, both lanes SHALL carry 0x00, underrun is set, and the word counter still advances; the HS stream never stalls.
REQ-029 CRC SHALL be CRC-16 with reflected polynomial 0x8408 (x^16+x^12+x^5+1) and init 0xFFFF.
- Processing order: lane0 byte, then lane1 byte, each LSB-first.
- No final XOR.
- Two bytes per cycle.
- The CRC register is reinitialised in HDR1.
REQ-030 The CRC state SHALL drive lane0=CRC[7:0] and lane1=CRC[15:8].
REQ-031 In TRAIL, each lane SHALL drive 0xFF if bit 7 of its previous byte was 0, else 0x00.
REQ-032 Timing:
- Start-to-first-SYNC latency = 1+PREP_CYCLES cycles.
- Total busy cycles = PREP_CYCLES + 3 + WC/2 + 1(long) + TRAIL_BYTES.
REQ-033 The payload counter SHALL be 15 bits and count WC/2 words. WC=0xFFFE SHALL produce exactly 32767 PAY cycles with no wrap.
REQ-034 A pkt_start while busy SHALL be ignored and SHALL NOT set pkt_err.
REQ-035 pkt_err and underrun SHALL clear only on reset or when a new packet is accepted.

Reset
REQ-036 While reset=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, asynchronously.
REQ-037 Reset mid-packet SHALL drop hs_req and byte_valid in the same cycle, with no trail sent.
REQ-038 After release, the first pkt_start SHALL be accepted on the first clock edge.

Verification
REQ-039 Short packet, VC=0, DT=0x00, WC=0x0001, PREP=4: hs_req at cycle 1; SYNC B8/B8 at cycle 5; HDR0 00/01; HDR1 00/1A; TRAIL x2 FF/FF; busy for 9 cycles.
REQ-040 Long packet, DT=0x2A, WC=0x0280, continuous pay_valid:
- HDR0 = 2A/80, HDR1 = 02/0E.
- Exactly 320 pay_ready handshakes.
- CRC bytes equal the bench CRC-16 (0x8408, init FFFF) model over the 640 bytes.
- underrun stays 0.
REQ-041 Long packet, WC=0x0004, pay_valid low on the 2nd PAY cycle: lanes 00/00 on that cycle; underrun=1; CRC is computed over the zeros; the packet length is unchanged.
REQ-042 Long packet with WC=0x0003: pkt_err=1, busy stays 0, hs_req stays 0. A following valid request clears pkt_err and is sent.
REQ-043 Assert reset during PAY of a 640-byte packet: hs_req, byte_valid and lanes go to 0 immediately. After release, a short packet is sent correctly.
REQ-044 Loopback through the receiver at WC=0x0280, DT=0x2A: the header is accepted with ECC syndrome 0, and the received payload matches the sent payload.
